alu_pkt_ctrl: RTL and testbench
===============================

Name: alu_pkt_ctrl

Overview:
Packet controller between the UART byte streams and the shared ALU datapath (adder, multiplier, divider). It parses request packets from the UART RX byte stream and folds the operands left-to-right through the ALU, one operation at a time, into an accumulator. It then returns the 32-bit result on the UART TX byte stream. The ALU may take one or many cycles per operation, as the divider does; the controller issues one operation and waits for its result.

Parameters:
- OPC_ADD, 8'h10, opcode selecting add (alu_op_o = 2'd0)
- OPC_MUL, 8'h11, opcode selecting multiply (alu_op_o = 2'd1)
- OPC_DIV, 8'h12, opcode selecting divide (alu_op_o = 2'd2)

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  controller accepts byte; transfer when valid & ready
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  UART TX accepts byte
- alu_valid_o  out  1  operation request
- alu_ready_i  in  1  ALU accepts request; transfer when valid & ready
- alu_op_o  out  2  0 add, 1 mul, 2 div
- alu_a_o  out  32  accumulator, the left operand
- alu_b_o  out  32  next operand
- alu_result_i  in  32  ALU result
- alu_result_valid_i  in  1  one-cycle pulse with the result
- busy_o  out  1  high in every state except OPC

Behaviour:
- Packet layout, bytes in order:
  - opcode
  - reserved byte, ignored
  - length LSB, then length MSB: N = number of 32-bit operands, 16 bits unsigned
  - N operands, each 4 bytes, little-endian
- Response: 4 bytes, little-endian 32-bit result.
- Reset outputs: rx_ready_o=0, tx_valid_o=0, tx_data_o=0, alu_valid_o=0, alu_op_o=0, alu_a_o=0, alu_b_o=0, busy_o=0.
- Reset internal state: state=OPC, all counters and accumulator cleared.
- Reset mid-packet or mid-operation: the partial packet is discarded and the next byte is treated as an opcode. Any alu_result_valid_i from an operation issued before reset is ignored.
- rx_ready_o is high only in OPC, RSV, LENL, LENH, OPND and DRAIN.
- States:
  - OPC: accept byte. Known opcode -> RSV, latch alu_op. Unknown opcode -> RSV with err flag set.
  - RSV -> LENL -> LENH: latch N. Then:
    - err=1 -> DRAIN (if N=0 -> SKIP)
    - N=0 -> RESP with acc=0
    - otherwise -> OPND
  - OPND: shift in 4 bytes.
    - First operand loads acc. If N=1 -> RESP; else -> OPND.
    - Later operands load b -> ISSUE.
  - ISSUE: alu_valid_o=1, with a, b and op held stable until alu_ready_i. Then -> WAIT.
  - WAIT: on alu_result_valid_i, acc <= alu_result_i. If this was the last operand -> RESP; else -> OPND.
  - RESP: send 4 bytes, LSB first. tx_valid_o holds until tx_ready_i; tx_data_o is stable while stalled. After the 4th byte -> OPC.
  - DRAIN: consume 4N bytes without issuing ALU operations -> SKIP.
  - SKIP: one cycle -> OPC, with no response (unless the optional feature is enabled).
- Operand counter is 16 bits and never wraps: N=16'hFFFF processes 65535 operands. The byte counter is 2 bits.
- Arithmetic is the ALU's, wrapping mod 2^32. Divide by zero is passed through unchecked; the result is whatever the divider returns.
- Fold order is strictly left-to-right: ((op0 ∘ op1) ∘ op2) ...
- Latency: the ISSUE cycle follows the cycle of the last byte of the second operand. The first TX byte is valid in the cycle after the final alu_result_valid_i.
- RX bytes are not accepted during ISSUE, WAIT or RESP; upstream buffers them.

Optional Feature:
- Macro: ALU_PKT_CTRL_ERR_RESP_EN.
- Defined: SKIP goes to RESP with acc=32'hFFFF_FFFF, so an unknown opcode returns bytes FF FF FF FF.
- Undefined: an unknown opcode packet is silently drained and no response is sent.

Test Plan:
- Add: bytes 10 00 02 00, 01 00 00 00, 02 00 00 00 -> TX 03 00 00 00, with exactly one ALU request.
- Multiply: 11 00 05 00, operands 1..5 -> TX 78 00 00 00 (120). Four ALU requests, with a values 1, 2, 6, 24.
- Divide with alu_ready_i delayed 3 cycles and result after 20 cycles: 12 00 02 00, 64, 8 -> TX 08 00 00 00. alu_a_o and alu_b_o stay stable while alu_valid_o is high.
- Length 1 and length 0:
  - add N=1, operand 0xDEADBEEF -> TX EF BE AD DE, no ALU request
  - N=0 -> TX 00 00 00 00
- Unknown opcode 13 00 02 00 plus 8 bytes, then add 3+4 -> no response for the first packet, then TX 07 00 00 00. With ALU_PKT_CTRL_ERR_RESP_EN defined, FF FF FF FF precedes 07 00 00 00.
- Backpressure and reset:
  - tx_ready_i low for 10 cycles mid-response -> no byte lost or duplicated
  - rst_i pulsed after 2 operand bytes -> all outputs return to reset values; the next full add packet 1+2 returns 03 00 00 00

Source files
------------

// File: rtl/alu_pkt_ctrl.sv
// rtl/alu_pkt_ctrl.sv - folds UART request packets through the shared ALU and returns a 32-bit result
// ALU_PKT_CTRL_ERR_RESP_EN: unknown opcodes answer FF FF FF FF instead of being dropped silently.
module alu_pkt_ctrl #(
  parameter logic [7:0] OPC_ADD = 8'h10,
  parameter logic [7:0] OPC_MUL = 8'h11,
  parameter logic [7:0] OPC_DIV = 8'h12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_OPC, S_RSV, S_LENL, S_LENH, S_OPND, S_ISSUE, S_WAIT, S_RESP, S_DRAIN, S_SKIP
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op;
  logic        err;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic [31:0] acc;
  logic [31:0] b;
  logic        rdy_q;
  logic        rx_fire;
  logic        tx_fire;
  logic [31:0] word;
  logic [15:0] len_in;

  assign rx_fire = rx_valid_i & rdy_q;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign word    = {rx_data_i, shreg};
  assign len_in  = {rx_data_i, len[7:0]};

  assign rx_ready_o = rdy_q;
  assign alu_op_o   = op;
  assign alu_a_o    = acc;
  assign alu_b_o    = b;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_OPC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    alu_valid_o = 1'b0;
    busy_o      = (state != S_OPC);
    case (state)
      S_OPC:  if (rx_fire) state_nxt = S_RSV;
      S_RSV:  if (rx_fire) state_nxt = S_LENL;
      S_LENL: if (rx_fire) state_nxt = S_LENH;
      S_LENH: begin
        if (rx_fire) begin
          if (err)                 state_nxt = (len_in == 16'd0) ? S_SKIP : S_DRAIN;
          else if (len_in == 16'd0) state_nxt = S_RESP;
          else                      state_nxt = S_OPND;
        end
      end
      S_OPND: begin
        if (rx_fire && byte_cnt == 2'd3) begin
          if (cnt == 16'd0) state_nxt = (len == 16'd1) ? S_RESP : S_OPND;
          else              state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_valid_o = 1'b1;
        if (alu_ready_i) state_nxt = S_WAIT;
      end
      // cnt already counts the operand just folded, so equality means the packet is done
      S_WAIT: if (alu_result_valid_i) state_nxt = (cnt == len) ? S_RESP : S_OPND;
      S_RESP: begin
        tx_valid_o = 1'b1;
        case (byte_cnt)
          2'd0:    tx_data_o = acc[7:0];
          2'd1:    tx_data_o = acc[15:8];
          2'd2:    tx_data_o = acc[23:16];
          default: tx_data_o = acc[31:24];
        endcase
        if (tx_fire && byte_cnt == 2'd3) state_nxt = S_OPC;
      end
      S_DRAIN: if (rx_fire && byte_cnt == 2'd3 && cnt == len - 16'd1) state_nxt = S_SKIP;
`ifdef ALU_PKT_CTRL_ERR_RESP_EN
      S_SKIP: state_nxt = S_RESP;
`else
      S_SKIP: state_nxt = S_OPC;
`endif
      default: state_nxt = S_OPC;
    endcase
  end

  // rx_ready is registered from the next state so it stays low through reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q    <= 1'b0;
      op       <= 2'd0;
      err      <= 1'b0;
      len      <= 16'd0;
      cnt      <= 16'd0;
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
      acc      <= 32'd0;
      b        <= 32'd0;
    end else begin
      rdy_q <= (state_nxt inside {S_OPC, S_RSV, S_LENL, S_LENH, S_OPND, S_DRAIN});
      case (state)
        S_OPC: begin
          byte_cnt <= 2'd0;
          cnt      <= 16'd0;
          if (rx_fire) begin
            err <= 1'b0;
            if (rx_data_i == OPC_ADD)      op <= 2'd0;
            else if (rx_data_i == OPC_MUL) op <= 2'd1;
            else if (rx_data_i == OPC_DIV) op <= 2'd2;
            else begin
              op  <= 2'd0;
              err <= 1'b1;
            end
          end
        end
        S_LENL: if (rx_fire) len[7:0] <= rx_data_i;
        S_LENH: begin
          if (rx_fire) begin
            len[15:8] <= rx_data_i;
            if (!err && len_in == 16'd0) acc <= 32'd0;
          end
        end
        S_OPND, S_DRAIN: begin
          if (rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {rx_data_i, shreg[23:8]};
            if (byte_cnt == 2'd3) begin
              cnt <= cnt + 16'd1;
              if (state == S_OPND) begin
                if (cnt == 16'd0) acc <= word;
                else              b   <= word;
              end
            end
          end
        end
        S_WAIT: if (alu_result_valid_i) acc <= alu_result_i;
        S_RESP: if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
`ifdef ALU_PKT_CTRL_ERR_RESP_EN
        S_SKIP: acc <= 32'hFFFF_FFFF;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// tb/tb_alu_pkt_ctrl.sv - scoreboard bench for alu_pkt_ctrl with randomized packets and ALU timing
// Honours ALU_PKT_CTRL_ERR_RESP_EN when predicting responses to unknown opcodes.
module tb_alu_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [1:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_res_valid;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  logic [7:0]  exp_tx[$];
  logic [65:0] exp_alu[$];
  logic [31:0] ops[$];
  int alu_rdy_dly = -1;
  int alu_lat     = -1;
  bit stall_req   = 1'b0;

  always #5 clk = ~clk;

  alu_pkt_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .alu_valid_o(alu_valid), .alu_ready_i(alu_ready), .alu_op_o(alu_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_result_valid_i(alu_res_valid),
    .busy_o(busy)
  );

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int g = 0;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    while (!rx_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      checks++;
      fails++;
      $display("FAIL rx_timeout: got no rx_ready expected rx_ready within 2000 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference: left fold over the operand list, plus the ALU request stream it implies
  task automatic send_pkt(input logic [7:0] opc);
    int n = ops.size();
    logic [15:0] n16;
    logic [31:0] acc;
    logic [31:0] w;
    logic [1:0]  op;
    n16 = 16'(n);
    op  = (opc == 8'h11) ? 2'd1 : (opc == 8'h12) ? 2'd2 : 2'd0;
    if (opc inside {8'h10, 8'h11, 8'h12}) begin
      acc = (n == 0) ? 32'd0 : ops[0];
      for (int i = 1; i < n; i++) begin
        exp_alu.push_back({op, acc, ops[i]});
        acc = alu_fn(op, acc, ops[i]);
      end
      for (int k = 0; k < 4; k++) exp_tx.push_back(acc[8*k +: 8]);
    end else begin
`ifdef ALU_PKT_CTRL_ERR_RESP_EN
      for (int k = 0; k < 4; k++) exp_tx.push_back(8'hFF);
`endif
    end
    send_byte(opc);
    send_byte(8'($urandom));
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = ops[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_tx.size() != 0 || busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 5000) begin
      fails++;
      $display("FAIL idle_timeout: got %0d bytes outstanding expected 0", exp_tx.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  rx_ready,  0);
    check({tag, "_tx_valid"},  tx_valid,  0);
    check({tag, "_tx_data"},   tx_data,   0);
    check({tag, "_alu_valid"}, alu_valid, 0);
    check({tag, "_alu_op"},    alu_op,    0);
    check({tag, "_alu_a"},     alu_a,     0);
    check({tag, "_alu_b"},     alu_b,     0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // TX monitor and backpressure source
  initial begin
    int stall = 0;
    int seen = 0;
    bit hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall > 0) begin
        tx_ready = 1'b0;
        stall--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (hold && tx_valid) check("tx_stable", tx_data, held);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL tx_extra: got byte %0h expected no byte", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", tx_data, e);
        end
        seen++;
        if (stall_req && (seen % 4) == 2) begin
          stall     = 10;
          stall_req = 1'b0;
        end
      end
      hold = tx_valid && !tx_ready;
      held = tx_data;
    end
  end

  // ALU model: variable accept delay and result latency
  initial begin
    bit pend = 1'b0;
    bit seen = 1'b0;
    bit hold = 1'b0;
    int lat = 0;
    int wait_cnt = 0;
    logic [31:0] res = 32'd0;
    logic [65:0] held = '0;
    logic [65:0] e;
    alu_ready     = 1'b0;
    alu_res_valid = 1'b0;
    alu_result    = 32'd0;
    forever begin
      @(negedge clk);
      alu_res_valid = 1'b0;
      if (pend) begin
        if (lat <= 1) begin
          alu_res_valid = 1'b1;
          alu_result    = res;
          pend          = 1'b0;
        end else begin
          lat--;
        end
      end
      if (alu_valid) begin
        if (hold) check("alu_stable", {alu_op, alu_a, alu_b}, held);
        if (!seen) begin
          seen     = 1'b1;
          wait_cnt = (alu_rdy_dly < 0) ? int'($urandom_range(0, 4)) : alu_rdy_dly;
        end
        if (wait_cnt > 0) begin
          alu_ready = 1'b0;
          wait_cnt--;
          hold = 1'b1;
          held = {alu_op, alu_a, alu_b};
        end else begin
          alu_ready = 1'b1;
          hold = 1'b0;
          seen = 1'b0;
          if (exp_alu.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL alu_extra: got request %0h expected none", {alu_op, alu_a, alu_b});
          end else begin
            e = exp_alu.pop_front();
            check("alu_req", {alu_op, alu_a, alu_b}, e);
          end
          res  = alu_fn(alu_op, alu_a, alu_b);
          pend = 1'b1;
          lat  = (alu_lat < 0) ? int'($urandom_range(1, 25)) : alu_lat;
        end
      end else begin
        alu_ready = 1'b0;
        seen = 1'b0;
        hold = 1'b0;
      end
    end
  end

  initial begin
    int r;
    int n;
    logic [7:0] opc;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    ops = {}; ops.push_back(32'd1); ops.push_back(32'd2);
    send_pkt(8'h10);

    ops = {};
    for (int i = 1; i <= 5; i++) ops.push_back(32'(i));
    send_pkt(8'h11);
    wait_idle();

    alu_rdy_dly = 3;
    alu_lat     = 20;
    ops = {}; ops.push_back(32'd64); ops.push_back(32'd8);
    send_pkt(8'h12);
    wait_idle();
    alu_rdy_dly = -1;
    alu_lat     = -1;

    ops = {}; ops.push_back(32'hDEAD_BEEF);
    send_pkt(8'h10);
    ops = {};
    send_pkt(8'h10);

    ops = {}; ops.push_back($urandom); ops.push_back($urandom);
    send_pkt(8'h13);
    ops = {}; ops.push_back(32'd3); ops.push_back(32'd4);
    send_pkt(8'h10);
    ops = {};
    send_pkt(8'h7E);

    wait_idle();
    stall_req = 1'b1;
    ops = {}; ops.push_back($urandom); ops.push_back($urandom); ops.push_back($urandom);
    send_pkt(8'h10);
    wait_idle();

    for (int p = 0; p < 25; p++) begin
      r   = int'($urandom_range(0, 9));
      opc = (r < 3) ? 8'h10 : (r < 6) ? 8'h11 : (r < 9) ? 8'h12 : 8'h5A;
      n   = int'($urandom_range(0, 5));
      ops = {};
      for (int i = 0; i < n; i++) begin
        if (opc == 8'h12 && i > 0) ops.push_back(32'($urandom_range(0, 300)));
        else                       ops.push_back($urandom);
      end
      send_pkt(opc);
    end
    wait_idle();

    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midpkt_reset");
    @(negedge clk);
    rst = 1'b0;
    ops = {}; ops.push_back(32'd1); ops.push_back(32'd2);
    send_pkt(8'h10);
    wait_idle();

    repeat (50) @(negedge clk);
    check("tx_leftover", exp_tx.size(), 0);
    check("alu_leftover", exp_alu.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
